// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM dead-time insertion stage.
// Latency: n/a (types only).
// Backpressure: n/a; the stage is free-running with no flow control.
//
// Contents:
//   DtCntDwDefault : default width of the per-channel dead-time counter.
//   dt_state_e     : per-channel output FSM state.
//   is_dead_band   : true for the two guard-band states.
package pwm_pkg;

    localparam int DtCntDwDefault = 8;

    typedef enum logic [2:0] {
        DT_OFF  = 3'd0,   // both sides off (reset, fault, disabled)
        DT_HS   = 3'd1,   // high side driven
        DT_LS   = 3'd2,   // low side driven
        DT_DB_H = 3'd3,   // guard band, heading to high side
        DT_DB_L = 3'd4    // guard band, heading to low side
    } dt_state_e;

    function automatic logic is_dead_band(input dt_state_e s);
        return (s == DT_DB_H) || (s == DT_DB_L);
    endfunction

endpackage

// File: rtl/pwm_deadtime_chan.sv
// One channel of dead-time insertion: FSM, guard-band counter, output registers.
// Latency: 1 cycle from registered pwm to outputs (outputs decode the next state).
// Backpressure: none; fault and disable force OFF on the next edge.
//
// Ports:
//   clk_core_i, rst_core_i : core clock, synchronous active-high reset
//   pwm_q_i                : PWM level, already registered by the top
//   enable_i, fault_i      : channel enable, global kill
//   dead_time_i            : guard band length in cycles, sampled only on counter load
//   hs_o, ls_o, dt_active_o: registered high-side / low-side / in-guard-band
module pwm_deadtime_chan
    import pwm_pkg::*;
#(
    parameter int DtCntDw = DtCntDwDefault
) (
    input  logic               clk_core_i,
    input  logic               rst_core_i,
    input  logic               pwm_q_i,
    input  logic               enable_i,
    input  logic               fault_i,
    input  logic [DtCntDw-1:0] dead_time_i,
    output logic               hs_o,
    output logic               ls_o,
    output logic               dt_active_o
);

    localparam logic [DtCntDw-1:0] CntOne = {{(DtCntDw-1){1'b0}}, 1'b1};

    dt_state_e          state_q, state_d;
    logic [DtCntDw-1:0] cnt_q, cnt_d;
    logic               dt_zero;
    logic [DtCntDw-1:0] dt_load;

    // The band state itself counts as one cycle, so the counter is loaded
    // with dead_time-1 and the exit happens on the cycle it reads 0. That
    // gives exactly dead_time both-low cycles. A zero dead time skips the
    // band entirely.
    assign dt_zero = (dead_time_i == '0);
    assign dt_load = dt_zero ? '0 : (dead_time_i - CntOne);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fault_i || !enable_i) begin
            state_d = DT_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DT_OFF: begin
                    // Leaving OFF always passes through a full guard band.
                    if (pwm_q_i) begin
                        state_d = dt_zero ? DT_HS : DT_DB_H;
                    end else begin
                        state_d = dt_zero ? DT_LS : DT_DB_L;
                    end
                    cnt_d = dt_load;
                end
                DT_LS: begin
                    if (pwm_q_i) begin
                        state_d = dt_zero ? DT_HS : DT_DB_H;
                        cnt_d   = dt_load;
                    end
                end
                DT_HS: begin
                    if (!pwm_q_i) begin
                        state_d = dt_zero ? DT_LS : DT_DB_L;
                        cnt_d   = dt_load;
                    end
                end
                DT_DB_H: begin
                    // Falling back to the side just vacated is safe: the
                    // target side was never driven during this band.
                    if (!pwm_q_i) begin
                        state_d = DT_LS;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = DT_HS;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                DT_DB_L: begin
                    if (pwm_q_i) begin
                        state_d = DT_HS;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = DT_LS;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = DT_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as the state register; HS and LS are mutually exclusive by construction.
    always_ff @(posedge clk_core_i) begin
        if (rst_core_i) begin
            state_q     <= DT_OFF;
            cnt_q       <= '0;
            hs_o        <= 1'b0;
            ls_o        <= 1'b0;
            dt_active_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hs_o        <= (state_d == DT_HS);
            ls_o        <= (state_d == DT_LS);
            dt_active_o <= is_dead_band(state_d);
        end
    end

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time insertion: turns NOutputs PWM waveforms into non-overlapping HS/LS pairs.
// Latency: 2 cycles pwm_i edge to first output change (input reg + state reg).
// Backpressure: none; fault_i or a dropped enable turns outputs off one cycle later.
//
// Ports:
//   clk_core_i, rst_core_i : core clock, synchronous active-high reset
//   pwm_i                  : PWM waveforms, one bit per channel
//   enable_i               : per-channel enable
//   dead_time_i            : channel c at [c*DtCntDw +: DtCntDw]
//   fault_i                : global kill
//   hs_o, ls_o             : high-side / low-side drives
//   dt_active_o            : channel currently inside a guard band
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int NOutputs = 6,
    parameter int DtCntDw  = DtCntDwDefault
) (
    input  logic                        clk_core_i,
    input  logic                        rst_core_i,
    input  logic [NOutputs-1:0]         pwm_i,
    input  logic [NOutputs-1:0]         enable_i,
    input  logic [NOutputs*DtCntDw-1:0] dead_time_i,
    input  logic                        fault_i,
    output logic [NOutputs-1:0]         hs_o,
    output logic [NOutputs-1:0]         ls_o,
    output logic [NOutputs-1:0]         dt_active_o
);

    logic [NOutputs-1:0] pwm_q;

    always_ff @(posedge clk_core_i) begin
        if (rst_core_i) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_i;
        end
    end

    for (genvar c = 0; c < NOutputs; c++) begin : g_chan
        pwm_deadtime_chan #(
            .DtCntDw (DtCntDw)
        ) u_chan (
            .clk_core_i  (clk_core_i),
            .rst_core_i  (rst_core_i),
            .pwm_q_i     (pwm_q[c]),
            .enable_i    (enable_i[c]),
            .fault_i     (fault_i),
            .dead_time_i (dead_time_i[c*DtCntDw +: DtCntDw]),
            .hs_o        (hs_o[c]),
            .ls_o        (ls_o[c]),
            .dt_active_o (dt_active_o[c])
        );
    end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Per-channel dead-time insertion stage sitting directly downstream of the PWM core output.
- Converts each single-ended PWM waveform into a complementary high-side/low-side pair. Both sides are guaranteed never active together, with a programmable guard band between them.
- Runs in the core clock domain. Feeds the pad outputs of a half-bridge driver.

Parameters:
- NOutputs, 6, number of channels.
- DtCntDw, 8, width of the per-channel dead-time count, in clock cycles.

Ports:
- clk_core_i  input  1  core clock.
- rst_core_i  input  1  synchronous, active-high reset.
- pwm_i  input  NOutputs  PWM waveforms from the PWM core.
- enable_i  input  NOutputs  per-channel enable.
- dead_time_i  input  NOutputs*DtCntDw  per-channel dead time in cycles; channel c occupies bits [c*DtCntDw +: DtCntDw].
- fault_i  input  1  global kill; forces every channel off.
- hs_o  output  NOutputs  high-side drive (follows pwm_i high).
- ls_o  output  NOutputs  low-side drive (follows pwm_i low).
- dt_active_o  output  NOutputs  channel is currently in a dead band.

Behaviour:
- Clocking and reset
  - Single clock domain; reset is synchronous, active-high.
  - All outputs are registered.
  - While rst_core_i is high: every state is OFF, pwm_q=0, counters=0, hs_o=0, ls_o=0, dt_active_o=0.
- Input stage: pwm_i is registered once into pwm_q. All decisions use pwm_q.
- Per-channel FSM states:
  - OFF: hs=0, ls=0.
  - HS: hs=1.
  - LS: ls=1.
  - DB_H: dead band heading to HS; both outputs 0, dt_active=1.
  - DB_L: dead band heading to LS; both outputs 0, dt_active=1.
- Output encoding: outputs are a registered decode of the next state, so they change in the same cycle the state changes.
- Transitions (evaluated in priority order):
  - fault_i=1 or enable_i[c]=0 -> OFF. Takes effect on the next edge, so outputs drop 1 cycle after assertion.
  - OFF, when enabled with no fault -> DB_H if pwm_q=1, else DB_L. The counter loads the full dead_time, so startup is always guarded.
  - LS and pwm_q=1 -> DB_H, counter loaded with dead_time_i[c].
  - HS and pwm_q=0 -> DB_L, counter loaded likewise.
  - LS/HS with dead_time=0 -> switch directly LS<->HS with no both-low cycle.
  - DB_H: counter decrements each cycle; on reaching 0 -> HS.
  - DB_L: counter decrements each cycle; on reaching 0 -> LS.
- Dead-band length: both outputs are low for exactly dead_time_i[c] cycles.
- Latency: pwm_i edge to first output change is 2 cycles (input register plus state register).
- Abort rule:
  - In DB_H, if pwm_q returns to 0 -> LS immediately.
  - In DB_L, if pwm_q returns to 1 -> HS immediately.
  - Returning to the side just vacated is always safe, because the opposite side was never driven.
  - Consequence: any pulse shorter than the dead time is swallowed.
- dead_time_i is sampled only at counter load. Changing it mid-band does not affect the current band.
- Counter is DtCntDw bits and never wraps; the terminal value 0 is checked before decrementing.
- Invariant: (hs_o[c] & ls_o[c]) == 0 in every cycle, including across reset and fault.
- Channels are fully independent; only fault_i and reset are shared.

Decomposition:
- Shared package pwm_pkg:
  - dt_state_e enum (OFF, HS, LS, DB_H, DB_L), 3-bit encoding.
  - Default constant DtCntDwDefault=8.
- Sub-module pwm_deadtime_chan:
  - Contains one channel's FSM, counter, and output registers.
  - The top registers pwm_i, slices dead_time_i, and instantiates NOutputs copies in a generate loop.

Test Plan:
- Reset/startup: dead_time=4, enable=1, pwm_i=0.
  - Reset 3 cycles, then release.
  - Required: hs=ls=0, dt_active=1 for 4 cycles, then ls_o=1.
  - hs_o is never 1.
- Nominal switching: dead_time=3, 50% square with period 20.
  - Each rising pwm_i edge: ls_o falls 2 cycles later, 3 cycles both-low, then hs_o rises.
  - Falling edges are symmetric.
  - Scoreboard checks hs&ls==0 every cycle.
- Zero dead time: dead_time=0, pwm_i toggles.
  - Required: ls_o 1->0 and hs_o 0->1 in the same cycle, 2 cycles after the edge.
  - dt_active stays 0.
- Short pulse abort: dead_time=5, pwm_i high for 2 cycles from LS.
  - Required: ls_o low for 2 cycles, then returns to 1.
  - hs_o stays 0 throughout.
- Fault mid-band, then recovery:
  - dead_time=10; assert fault_i during DB_H at count 6.
  - Required: state OFF next cycle, all outputs 0 while fault is high.
  - On release with pwm_q=1: a full 10-cycle band, then hs_o=1.
- Mid-band dead_time change, plus channel independence:
  - Channel 0 has dead_time=6; change it to 2 during its band.
  - Required: the current band still lasts 6 cycles.
  - Channel 1 (disabled) holds hs=ls=0 throughout.
